mod4051_seq_reducer: RTL and testbench

//  Sequential controller that reduces a 200-bit operand modulo 4051 using the per-chunk residue LUT bank.
//  The operand is split into 34 six-bit chunks; chunk k carries weight 2^(6k).

---
 rtl/mod4051_pkg.sv | 40 ++++
 rtl/mod4051_lut_bank.sv | 38 +++
 rtl/mod4051_seq_reducer.sv | 132 +++++++++++++
 tb/tb_mod4051_seq_reducer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mod4051_pkg.sv
// ---------------------------------------------------------------------------
// mod4051_pkg
//   Shared constants and types for the modulo-4051 sequential reducer.
//   No ports. Provides:
//     MODULUS, N_BITS, CHUNK_W, N_CHUNKS, RES_W, IDX_W, OP_W  constants
//     state_t      controller FSM state
//     res_t        residue word (0..MODULUS-1)
//     chunk_weight 2^(CHUNK_W*k) mod MODULUS, evaluated at elaboration time
// ---------------------------------------------------------------------------
package mod4051_pkg;

  localparam int MODULUS  = 4051;
  localparam int N_BITS   = 200;
  localparam int CHUNK_W  = 6;
  localparam int N_CHUNKS = 34;
  localparam int RES_W    = 12;
  localparam int IDX_W    = 6;
  // Operand register width: the top chunk is zero-extended to a full chunk.
  localparam int OP_W     = N_CHUNKS * CHUNK_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [RES_W-1:0] res_t;

  // Weight of chunk k reduced mod MODULUS; only ever called with constants.
  function automatic int chunk_weight(input int k);
    int w;
    w = 1;
    for (int i = 0; i < k; i++) begin
      w = (w * (1 << CHUNK_W)) % MODULUS;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod4051_lut_bank.sv
// ---------------------------------------------------------------------------
// mod4051_lut_bank
//   Bank of per-chunk residue tables X_0..X_33. Table k maps a 6-bit chunk c
//   to (c << 6k) mod 4051. The selected table output is muxed out.
//   Purely combinational.
// Ports:
//   chunk    in   CHUNK_W  chunk value presented to every table
//   sel      in   IDX_W    chunk position (table select)
//   lut_out  out  RES_W    residue of the chunk at that position; 0 if sel
//                          is out of range
// ---------------------------------------------------------------------------
module mod4051_lut_bank
  import mod4051_pkg::*;
(
  input  logic [CHUNK_W-1:0] chunk,
  input  logic [IDX_W-1:0]   sel,
  output res_t               lut_out
);

  res_t x [N_CHUNKS];

  // Each table is a constant multiply-and-reduce over a 6-bit input, which
  // synthesis folds into a 64-entry ROM. 63*4050 fits comfortably in 18 bits.
  for (genvar k = 0; k < N_CHUNKS; k++) begin : g_lut
    localparam logic [17:0] WEIGHT = 18'(chunk_weight(k));
    logic [17:0] prod;
    assign prod = 18'(chunk) * WEIGHT;
    assign x[k] = res_t'(prod % 18'(MODULUS));
  end

  always_comb begin
    lut_out = '0;
    if (sel < IDX_W'(N_CHUNKS)) begin
      lut_out = x[sel];
    end
  end

endmodule

// File: rtl/mod4051_seq_reducer.sv
// ---------------------------------------------------------------------------
// mod4051_seq_reducer
//   Reduces a 200-bit operand modulo 4051, one 6-bit chunk per cycle.
//   IDLE accepts an operand, ACCUM folds 34 chunk residues into acc,
//   FINAL publishes acc, DONE holds the result until the consumer takes it.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operand offered
//   in_ready   out  1       block can accept an operand (IDLE only)
//   in_data    in   N_BITS  operand
//   out_valid  out  1       residue available (DONE)
//   out_ready  in   1       consumer accepts the residue
//   out_data   out  RES_W   in_data mod 4051; holds until the next FINAL
//   busy       out  1       FSM is in ACCUM or FINAL
// ---------------------------------------------------------------------------
module mod4051_seq_reducer
  import mod4051_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              busy
);

  state_t            state;
  logic [OP_W-1:0]   op_q;
  res_t              acc;
  logic [IDX_W-1:0]  idx;

  logic [CHUNK_W-1:0] chunks [N_CHUNKS];
  logic [CHUNK_W-1:0] chunk;
  res_t               lut_out;
  res_t               acc_next;

  // Both operands are below MODULUS, so one conditional subtract keeps the
  // sum in range.
  function automatic res_t mod_add(input res_t a, input res_t b);
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (RES_W+1)'(MODULUS)) begin
      sum = sum - (RES_W+1)'(MODULUS);
    end
    return sum[RES_W-1:0];
  endfunction

  for (genvar k = 0; k < N_CHUNKS; k++) begin : g_chunk
    assign chunks[k] = op_q[k*CHUNK_W +: CHUNK_W];
  end

  always_comb begin
    chunk = '0;
    if (idx < IDX_W'(N_CHUNKS)) begin
      chunk = chunks[idx];
    end
  end

  mod4051_lut_bank u_lut_bank (
    .chunk   (chunk),
    .sel     (idx),
    .lut_out (lut_out)
  );

  assign acc_next = mod_add(acc, lut_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= {{(OP_W-N_BITS){1'b0}}, in_data};
            acc      <= '0;
            idx      <= '0;
            state    <= ACCUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (idx >= IDX_W'(N_CHUNKS)) begin
            // Unreachable index: abandon the operation rather than emit garbage.
            state    <= IDLE;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            acc <= acc_next;
            if (idx == IDX_W'(N_CHUNKS-1)) begin
              state <= FINAL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FINAL: begin
          out_data  <= acc;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod4051_seq_reducer.sv
// ---------------------------------------------------------------------------
// tb_mod4051_seq_reducer
//   Directed and randomised checks of mod4051_seq_reducer against
//   hand-computed residues and a bit-serial reference reduction.
// ---------------------------------------------------------------------------
module tb_mod4051_seq_reducer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [11:0]  out_data;
  logic         busy;

  int checks;
  int failures;

  mod4051_seq_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // MSB-first shift-and-reduce; independent of the chunk/LUT decomposition.
  function automatic int gold(input logic [199:0] d);
    int r;
    r = 0;
    for (int i = 199; i >= 0; i--) begin
      r = (r * 2 + int'(d[i])) % 4051;
    end
    return r;
  endfunction

  // Offers an operand, returns one negedge after the accepting edge.
  task automatic send(input logic [199:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  // Waits for out_valid (bounded), checks the residue, then hands it off.
  task automatic recv(input string tag, input int exp, input int ready_delay,
                      output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_data, exp);
    repeat (ready_delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    int exp_r;
    logic stable;
    logic [199:0] d;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero operand, latency and busy/in_ready during the operation
    send(200'd0);
    chk("busy_accum", busy, 1);
    chk("in_ready_accum", in_ready, 0);
    recv("zero", 0, 0, lat);
    chk("latency", lat, 35);
    chk("in_ready_after", in_ready, 1);

    // 2: wrap-around near the modulus
    send(200'd4051);
    recv("m", 0, 0, lat);
    send(200'd4052);
    recv("m_plus1", 1, 1, lat);
    send(200'd8101);
    recv("2m_minus1", 4050, 0, lat);

    // 3: weights across chunk boundaries
    send(200'd1 << 12);
    recv("pow12", 45, 0, lat);
    send(200'd1 << 24);
    recv("pow24", 2025, 0, lat);

    // 4: extremes against the reference
    d = 200'd1 << 199;
    send(d);
    recv("pow199", gold(d), 0, lat);
    d = '1;
    send(d);
    recv("all_ones", gold(d), 2, lat);

    // 5a: consumer stall holds the result
    send(200'd8101);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 12'd4050) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release", out_valid, 0);

    // 5b: in_valid during ACCUM is ignored
    send(200'd1 << 12);
    repeat (5) @(negedge clk);
    chk("accum_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 200'd4052;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    recv("ignored_pulse", 45, 0, lat);
    chk("ignored_latency", lat + 8, 35);
    repeat (3) @(negedge clk);
    chk("no_extra_result", out_valid, 0);
    chk("idle_busy", busy, 0);

    // 6: reset mid-ACCUM abandons the operation
    send({8{25'h1abcdef}});
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(200'd4052);
    recv("after_rst", 1, 0, lat);

    // 4b: random operands with random gaps on both handshakes
    for (int i = 0; i < 1000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp_r = gold(d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d);
      recv("random", exp_r, $urandom_range(0, 3), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
